ctrl_seq: RTL and testbench
===========================

// Module: ctrl_seq
// PURPOSE
//  Fetch/decode/execute sequencer for the 8-bit accumulator CPU. Drives the
//  decode/execute phase inputs of the instruction decoder, handshakes instruction
//  fetch with memory and IN/OUT with the I/O port, and turns decoded
//  instruction strobes plus Z/C flags into register write enables and PC control.
// PARAMETERS
//  TMO_W   4   width of ack-timeout counter; timeout = 2**TMO_W-1 cycles without ack
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  run        in   1  level: keep executing instructions
//  step       in   1  one-cycle pulse: execute exactly one instruction (sampled in IDLE)
//  mem_ack    in   1  instruction word valid on memory bus
//  io_ack     in   1  I/O port completed read/write
//  dec_add, dec_sub, dec_bitand, dec_load, dec_inp, dec_outp  in 1 each  decoder strobes
//  dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc     in 1 each  decoder strobes
//  z, c       in   1  zero / carry flags from ALU flag register
//  fetch, decode, execute  out 1  phase indicators (decode/execute feed decoder)
//  mem_rd     out  1  instruction read request
//  ir_en      out  1  load IR from memory bus
//  pc_inc     out  1  PC <= PC+1
//  pc_load    out  1  PC <= IR operand (taken jump)
//  acc_en     out  1  accumulator write enable
//  flag_en    out  1  Z/C flag write enable
//  io_rd, io_wr   out  1  I/O read / write request
//  halted     out  1  sequencer in IDLE or ERR
//  err        out  1  sticky fault (timeout or illegal decode)
// BEHAVIOUR
//  States IDLE, FETCH, DECODE, EXEC, IOWAIT, ERR. Outputs are Moore from state
//  except strobes noted as ack-qualified (combinational on ack, same cycle).
//  Reset (async): state=IDLE; halted=1; every other output 0; timeout ctr=0.
//  IDLE: halted=1. run=1 or step=1 -> FETCH. step ignored in other states.
//  FETCH: fetch=1, mem_rd=1 held until mem_ack. Cycle with mem_ack=1: ir_en=1,
//   pc_inc=1, -> DECODE. mem_ack outside FETCH ignored.
//  DECODE: decode=1 for exactly one cycle -> EXEC.
//  EXEC: execute=1 one cycle. Strobe count among {add,sub,bitand,load,inp,outp,
//   jump*}: 0 -> NOP, no enables; >1 -> ERR.
//   add/sub/bitand: acc_en=1, flag_en=1. load: acc_en=1 only.
//   taken = jump | jumpz&z | jumpnz&~z | jumpc&c | jumpnc&~c; pc_load=taken.
//   Untaken conditional jump: no enables.
//   inp/outp: io_rd/io_wr=1, latch direction, -> IOWAIT (never completes in EXEC).
//  IOWAIT: execute=1, io_rd or io_wr held per latched direction until io_ack.
//   Ack cycle: acc_en=1 if inp; instruction done. io_ack outside IOWAIT ignored.
//  Instruction done (EXEC non-IO, or IOWAIT ack): run=1 -> FETCH, else -> IDLE.
//   Dropping run mid-instruction finishes the instruction, then IDLE.
//  Timeout: counter cleared on entry to FETCH/IOWAIT, +1 per cycle without ack;
//   reaching 2**TMO_W-1 -> ERR (ack in that same cycle wins, no error).
//  ERR: err=1, halted=1, all strobes/requests 0; left only by rst_n.
//  Latency: min 3 cycles/instruction (ack in 1st FETCH cycle, non-IO op);
//   IO ops 4 + io_ack wait cycles. Exactly one of fetch/decode/execute high
//   outside IDLE/ERR; none high in IDLE/ERR.
// TESTING
//  1 rst_n=0 asserted mid-FETCH, mem_rd=1 -> same cycle mem_rd=0, fetch=0, halted=1, err=0.
//  2 run=1, mem_ack=1, dec_add in EXEC -> fetch/decode/execute period 3; pc_inc+ir_en
//    in FETCH cycle only; acc_en+flag_en in EXEC cycle only.
//  3 dec_jumpz with z=1 -> pc_load=1 in EXEC; repeat with z=0 -> pc_load=0, no enables;
//    dec_jumpc c=0 -> pc_load=0; dec_jumpnc c=0 -> pc_load=1.
//  4 dec_inp, io_ack rises 3 cycles after EXEC -> io_rd high 4 cycles, execute high
//    4 cycles, acc_en=1 only on ack cycle, then fetch=1 next cycle.
//  5 run=0, single step pulse in IDLE -> one full instruction, return IDLE halted=1;
//    step pulse during FETCH ignored (no second instruction).
//  6 TMO_W=4, mem_ack held 0 -> err=1 after 15 FETCH cycles, sticky until rst_n;
//    separately dec_add+dec_load together in EXEC -> ERR, no acc_en.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// Signal bundle between the fetch/decode/execute sequencer and its datapath,
// memory and I/O neighbours. The sequencer uses the master modport.
interface ctrl_seq_if;
    logic run, step;
    logic mem_ack, io_ack;
    logic dec_add, dec_sub, dec_bitand, dec_load, dec_inp, dec_outp;
    logic dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc;
    logic z, c;

    logic fetch, decode, execute;
    logic mem_rd, ir_en, pc_inc, pc_load;
    logic acc_en, flag_en;
    logic io_rd, io_wr;
    logic halted, err;

    modport master (
        input  run, step, mem_ack, io_ack,
        input  dec_add, dec_sub, dec_bitand, dec_load, dec_inp, dec_outp,
        input  dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc,
        input  z, c,
        output fetch, decode, execute, mem_rd, ir_en, pc_inc, pc_load,
        output acc_en, flag_en, io_rd, io_wr, halted, err
    );

    modport slave (
        output run, step, mem_ack, io_ack,
        output dec_add, dec_sub, dec_bitand, dec_load, dec_inp, dec_outp,
        output dec_jump, dec_jumpz, dec_jumpnz, dec_jumpc, dec_jumpnc,
        output z, c,
        input  fetch, decode, execute, mem_rd, ir_en, pc_inc, pc_load,
        input  acc_en, flag_en, io_rd, io_wr, halted, err
    );
endinterface

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: Moore phase
// outputs, ack-qualified strobes, ack timeout and a sticky error state.
module ctrl_seq #(
    parameter int TMO_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    ctrl_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_IOWAIT, S_ERR
    } state_e;

    // Counter value seen in the last allowed wait cycle (2**TMO_W-2).
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             io_dir_q, io_dir_d;   // 1 = read (inp), 0 = write (outp)

    logic [10:0] strobes;
    logic        multi, taken, io_op, alu_op;

    logic fetch, decode, execute, mem_rd, ir_en, pc_inc, pc_load;
    logic acc_en, flag_en, io_rd, io_wr, halted, err;

    assign strobes = {bus.dec_add, bus.dec_sub, bus.dec_bitand, bus.dec_load,
                      bus.dec_inp, bus.dec_outp, bus.dec_jump, bus.dec_jumpz,
                      bus.dec_jumpnz, bus.dec_jumpc, bus.dec_jumpnc};
    assign multi   = |(strobes & (strobes - 11'd1));
    assign taken   = bus.dec_jump | (bus.dec_jumpz & bus.z) | (bus.dec_jumpnz & ~bus.z)
                   | (bus.dec_jumpc & bus.c) | (bus.dec_jumpnc & ~bus.c);
    assign io_op   = bus.dec_inp | bus.dec_outp;
    assign alu_op  = bus.dec_add | bus.dec_sub | bus.dec_bitand;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        tmo_d    = '0;
        io_dir_d = io_dir_q;
        fetch    = 1'b0;
        decode   = 1'b0;
        execute  = 1'b0;
        mem_rd   = 1'b0;
        ir_en    = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        acc_en   = 1'b0;
        flag_en  = 1'b0;
        io_rd    = 1'b0;
        io_wr    = 1'b0;
        halted   = 1'b0;
        err      = 1'b0;

        case (state_q)
            S_IDLE: begin
                halted = 1'b1;
                if (bus.run || bus.step) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch  = 1'b1;
                mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    ir_en   = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_DECODE: begin
                decode  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                execute = 1'b1;
                if (multi) begin
                    state_d = S_ERR;
                end else if (io_op) begin
                    io_rd    = bus.dec_inp;
                    io_wr    = bus.dec_outp;
                    io_dir_d = bus.dec_inp;
                    state_d  = S_IOWAIT;
                end else begin
                    acc_en  = alu_op | bus.dec_load;
                    flag_en = alu_op;
                    pc_load = taken;
                    state_d = bus.run ? S_FETCH : S_IDLE;
                end
            end
            S_IOWAIT: begin
                execute = 1'b1;
                io_rd   = io_dir_q;
                io_wr   = ~io_dir_q;
                if (bus.io_ack) begin
                    acc_en  = io_dir_q;
                    state_d = bus.run ? S_FETCH : S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_ERR: begin
                err    = 1'b1;
                halted = 1'b1;
            end
            default: state_d = S_ERR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; all outputs decode from
    // state_q, so asserting rst_n clears them in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmo_q    <= '0;
            io_dir_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmo_q    <= tmo_d;
            io_dir_q <= io_dir_d;
        end
    end

    assign bus.fetch   = fetch;
    assign bus.decode  = decode;
    assign bus.execute = execute;
    assign bus.mem_rd  = mem_rd;
    assign bus.ir_en   = ir_en;
    assign bus.pc_inc  = pc_inc;
    assign bus.pc_load = pc_load;
    assign bus.acc_en  = acc_en;
    assign bus.flag_en = flag_en;
    assign bus.io_rd   = io_rd;
    assign bus.io_wr   = io_wr;
    assign bus.halted  = halted;
    assign bus.err     = err;

endmodule

// File: tb/tb_ctrl_seq.sv
// Scoreboard bench for ctrl_seq: stimulus pushes the hand-computed output vector
// expected for each cycle; a monitor pops and compares it on the falling edge.
module tb_ctrl_seq;

    typedef logic [12:0] outv_t;
    typedef struct {
        string name;
        outv_t exp;
    } exp_t;

    localparam outv_t O_FETCH = 13'(1) << 12;
    localparam outv_t O_DEC   = 13'(1) << 11;
    localparam outv_t O_EXEC  = 13'(1) << 10;
    localparam outv_t O_MRD   = 13'(1) << 9;
    localparam outv_t O_IREN  = 13'(1) << 8;
    localparam outv_t O_PCINC = 13'(1) << 7;
    localparam outv_t O_PCLD  = 13'(1) << 6;
    localparam outv_t O_ACC   = 13'(1) << 5;
    localparam outv_t O_FLAG  = 13'(1) << 4;
    localparam outv_t O_IORD  = 13'(1) << 3;
    localparam outv_t O_IOWR  = 13'(1) << 2;
    localparam outv_t O_HALT  = 13'(1) << 1;
    localparam outv_t O_ERR   = 13'(1);

    localparam outv_t E_FETCH = O_FETCH | O_MRD;
    localparam outv_t E_FACK  = O_FETCH | O_MRD | O_IREN | O_PCINC;
    localparam outv_t E_ERR   = O_ERR | O_HALT;

    // Decoder strobe order: add sub bitand load inp outp jump jumpz jumpnz jumpc jumpnc
    localparam logic [10:0] D_NONE   = 11'b000_0000_0000;
    localparam logic [10:0] D_ADD    = 11'b100_0000_0000;
    localparam logic [10:0] D_SUB    = 11'b010_0000_0000;
    localparam logic [10:0] D_AND    = 11'b001_0000_0000;
    localparam logic [10:0] D_LOAD   = 11'b000_1000_0000;
    localparam logic [10:0] D_INP    = 11'b000_0100_0000;
    localparam logic [10:0] D_OUTP   = 11'b000_0010_0000;
    localparam logic [10:0] D_JUMP   = 11'b000_0001_0000;
    localparam logic [10:0] D_JUMPZ  = 11'b000_0000_1000;
    localparam logic [10:0] D_JUMPNZ = 11'b000_0000_0100;
    localparam logic [10:0] D_JUMPC  = 11'b000_0000_0010;
    localparam logic [10:0] D_JUMPNC = 11'b000_0000_0001;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    ctrl_seq_if b();

    ctrl_seq #(.TMO_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic outv_t sample();
        return {b.fetch, b.decode, b.execute, b.mem_rd, b.ir_en, b.pc_inc, b.pc_load,
                b.acc_en, b.flag_en, b.io_rd, b.io_wr, b.halted, b.err};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, 32'(sample()), 32'(e.exp));
            end
        end
    end

    task automatic set_ops(input logic [10:0] v);
        {b.dec_add, b.dec_sub, b.dec_bitand, b.dec_load, b.dec_inp, b.dec_outp,
         b.dec_jump, b.dec_jumpz, b.dec_jumpnz, b.dec_jumpc, b.dec_jumpnc} = v;
    endtask

    // Inputs for the current cycle are already applied; queue its expectation.
    task automatic cyc(input string name, input outv_t exp);
        exp_q.push_back('{name, exp});
        @(posedge clk);
        #1;
    endtask

    // Fetch acked in its first cycle, then decode, then execute with the given ops.
    task automatic instr(input string name, input logic [10:0] ops,
                         input logic zf, input logic cf, input outv_t exec_exp);
        b.mem_ack = 1'b1;
        cyc({name, ".fetch"}, E_FACK);
        b.mem_ack = 1'b0;
        cyc({name, ".decode"}, O_DEC);
        set_ops(ops);
        b.z = zf;
        b.c = cf;
        cyc({name, ".exec"}, O_EXEC | exec_exp);
        set_ops(D_NONE);
    endtask

    initial begin : stimulus
        rst_n    = 1'b0;
        b.run    = 1'b0;
        b.step   = 1'b0;
        b.mem_ack = 1'b0;
        b.io_ack = 1'b0;
        b.z      = 1'b0;
        b.c      = 1'b0;
        set_ops(D_NONE);
        @(posedge clk);
        #1;
        cyc("reset", O_HALT);
        rst_n = 1'b1;
        cyc("idle", O_HALT);

        // Back-to-back instructions at the 3-cycle minimum
        b.run = 1'b1;
        cyc("idle_run", O_HALT);
        instr("add",    D_ADD,    1'b0, 1'b0, O_ACC | O_FLAG);
        instr("sub",    D_SUB,    1'b0, 1'b0, O_ACC | O_FLAG);
        instr("bitand", D_AND,    1'b0, 1'b0, O_ACC | O_FLAG);
        instr("load",   D_LOAD,   1'b0, 1'b0, O_ACC);
        instr("nop",    D_NONE,   1'b0, 1'b0, '0);

        // Jump conditions
        instr("jumpz_t",  D_JUMPZ,  1'b1, 1'b0, O_PCLD);
        instr("jumpz_n",  D_JUMPZ,  1'b0, 1'b0, '0);
        instr("jumpc_n",  D_JUMPC,  1'b0, 1'b0, '0);
        instr("jumpnc_t", D_JUMPNC, 1'b0, 1'b0, O_PCLD);
        instr("jumpnz_t", D_JUMPNZ, 1'b0, 1'b1, O_PCLD);
        instr("jump",     D_JUMP,   1'b1, 1'b1, O_PCLD);

        // Fetch wait states; io_ack in FETCH is ignored; mem_ack outside FETCH ignored
        b.io_ack = 1'b1;
        cyc("fw.wait0", E_FETCH);
        b.io_ack = 1'b0;
        cyc("fw.wait1", E_FETCH);
        b.mem_ack = 1'b1;
        cyc("fw.fetch", E_FACK);
        cyc("fw.decode", O_DEC);
        set_ops(D_ADD);
        cyc("fw.exec", O_EXEC | O_ACC | O_FLAG);
        set_ops(D_NONE);
        b.mem_ack = 1'b0;

        // IN with io_ack three cycles after EXEC
        instr("inp", D_INP, 1'b0, 1'b0, O_IORD);
        cyc("inp.wait1", O_EXEC | O_IORD);
        cyc("inp.wait2", O_EXEC | O_IORD);
        b.io_ack = 1'b1;
        cyc("inp.ack", O_EXEC | O_IORD | O_ACC);
        b.io_ack = 1'b0;
        // OUT with immediate ack: no accumulator write
        instr("outp", D_OUTP, 1'b0, 1'b0, O_IOWR);
        b.io_ack = 1'b1;
        cyc("outp.ack", O_EXEC | O_IOWR);
        b.io_ack = 1'b0;

        // Dropping run mid-instruction finishes it, then IDLE
        b.mem_ack = 1'b1;
        cyc("drop.fetch", E_FACK);
        b.mem_ack = 1'b0;
        b.run = 1'b0;
        cyc("drop.decode", O_DEC);
        set_ops(D_LOAD);
        cyc("drop.exec", O_EXEC | O_ACC);
        set_ops(D_NONE);
        cyc("drop.idle", O_HALT);

        // Single step; a step pulse during FETCH is ignored
        b.step = 1'b1;
        cyc("step.idle", O_HALT);
        cyc("step.fetch0", E_FETCH);
        b.step = 1'b0;
        instr("step", D_ADD, 1'b0, 1'b0, O_ACC | O_FLAG);
        cyc("step.idle1", O_HALT);
        cyc("step.idle2", O_HALT);

        // Ack on the last permitted fetch cycle wins over the timeout
        b.step = 1'b1;
        cyc("late.idle", O_HALT);
        b.step = 1'b0;
        for (int i = 1; i <= 14; i++) cyc($sformatf("late.fetch%0d", i), E_FETCH);
        instr("late", D_NONE, 1'b0, 1'b0, '0);
        cyc("late.idle1", O_HALT);

        // Fetch timeout: 15 unacked cycles, then sticky ERR
        b.step = 1'b1;
        cyc("tmo.idle", O_HALT);
        b.step = 1'b0;
        for (int i = 1; i <= 15; i++) cyc($sformatf("tmo.fetch%0d", i), E_FETCH);
        b.run = 1'b1;
        b.step = 1'b1;
        b.mem_ack = 1'b1;
        b.io_ack = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("tmo.err%0d", i), E_ERR);
        b.run = 1'b0;
        b.step = 1'b0;
        b.mem_ack = 1'b0;
        b.io_ack = 1'b0;
        rst_n = 1'b0;
        cyc("tmo.reset", O_HALT);
        rst_n = 1'b1;
        cyc("tmo.idle_after", O_HALT);

        // Two strobes at once: no enables, then ERR
        b.run = 1'b1;
        cyc("multi.idle", O_HALT);
        instr("multi", D_ADD | D_LOAD, 1'b0, 1'b0, '0);
        b.run = 1'b0;
        cyc("multi.err0", E_ERR);
        cyc("multi.err1", E_ERR);
        rst_n = 1'b0;
        cyc("multi.reset", O_HALT);
        rst_n = 1'b1;

        // Asynchronous reset asserted mid-FETCH clears outputs in the same cycle
        b.run = 1'b1;
        cyc("arst.idle", O_HALT);
        cyc("arst.fetch", E_FETCH);
        rst_n = 1'b0;
        b.run = 1'b0;
        cyc("arst.assert", O_HALT);
        rst_n = 1'b1;
        cyc("arst.idle_after", O_HALT);

        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
